// File: rtl/rv32_div_ext.sv
// rv32_div_ext: iterative RV32M DIV/DIVU/REM/REMU unit, radix-2 restoring, one quotient bit per cycle
//   clk   : system clock, rising edge
//   rst   : asynchronous active-low reset
//   start : request, sampled in IDLE only; func3[2]=0 (mul codes) ignored
//   a, b  : dividend / divisor, latched with an accepted start
//   func3 : 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   r     : result, updated only when finishing, held until the next result
//   done  : one-cycle pulse when r is valid
//   busy  : high in every state except IDLE
module rv32_div_ext (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  func3,
  output logic [31:0] r,
  output logic        done,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t      state;
  logic [31:0] rem, quo, dvs, a_abs, b_abs, res;
  logic [32:0] sh, diff;
  logic [4:0]  cnt;
  logic        neg, sel_rem, sgn, dz, ovf;
  assign sgn   = ~func3[0];
  assign a_abs = sgn && a[31] ? -a : a;
  assign b_abs = sgn && b[31] ? -b : b;
  assign dz    = b == 32'd0;
  assign ovf   = sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  assign sh    = {rem, quo[31]};
  assign diff  = sh - {1'b0, dvs};
  assign res   = sel_rem ? rem : quo;
  assign busy  = state != IDLE;
  // Special cases preset quo (division result) and rem (remainder result) so FIX
  // selects the right one with the sign correction disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      r       <= '0;
      done    <= 1'b0;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      neg     <= 1'b0;
      sel_rem <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && func3[2]) begin
          sel_rem <= func3[1];
          cnt     <= '0;
          if (dz || ovf) begin
            state <= FIX;
            neg   <= 1'b0;
            quo   <= dz ? 32'hFFFF_FFFF : 32'h8000_0000;
            rem   <= dz ? a : 32'd0;
          end else begin
            state <= RUN;
            neg   <= sgn && (func3[1] ? a[31] : a[31] ^ b[31]);
            quo   <= a_abs;
            rem   <= '0;
            dvs   <= b_abs;
          end
        end
        RUN: begin
          rem   <= diff[32] ? sh[31:0] : diff[31:0];
          quo   <= {quo[30:0], ~diff[32]};
          cnt   <= cnt + 5'd1;
          state <= cnt == 5'd31 ? FIX : RUN;
        end
        FIX: begin
          r     <= neg ? -res : res;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32_div_ext.sv
// tb_rv32_div_ext: table-driven scoreboard bench for rv32_div_ext
module tb_rv32_div_ext;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [31:0] a = '0, b = '0, r;
  logic [2:0]  func3 = '0;
  logic        done, busy;
  int          checks = 0, errors = 0;
  logic [31:0] q[$];
  typedef struct {
    logic [2:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] e;
    int          lat;
  } vec_t;
  vec_t vec[19];

  rv32_div_ext dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b), .func3(func3),
                    .r(r), .done(done), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] e, input int lat, input bit poke);
    int n = 0;
    bit got = 0;
    @(negedge clk);
    func3 = f; a = x; b = y; start = 1'b1;
    q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    while (n < 60 && !got) begin
      @(negedge clk);
      if (n == 0) chk("busy_during", {31'd0, busy}, 32'd1);
      if (done) got = 1;
      else begin
        if (poke && n == 5) begin
          start = 1'b1; func3 = 3'b101; a = 32'd1; b = 32'd1;
        end else start = 1'b0;
        @(posedge clk);
        n++;
      end
    end
    start = 1'b0;
    chk("latency", got ? n : -1, lat);
    if (got) chk($sformatf("result f=%0b a=%08h b=%08h", f, x, y), r, q.pop_front());
    else void'(q.pop_front());
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("r_held", r, e);
  endtask

  task automatic quiet(input int cyc);
    int pulses = 0, busys = 0;
    repeat (cyc) begin
      @(negedge clk);
      pulses += done;
      busys  += busy;
    end
    chk("no_done", pulses, 0);
    chk("no_busy", busys, 0);
  endtask

  initial begin
    vec[0]  = '{3'b100, 32'd100,        32'd7,          32'h0000_000E, 33};
    vec[1]  = '{3'b110, 32'd100,        32'd7,          32'h0000_0002, 33};
    vec[2]  = '{3'b100, -32'd100,       32'd7,          32'hFFFF_FFF2, 33};
    vec[3]  = '{3'b110, -32'd100,       32'd7,          32'hFFFF_FFFE, 33};
    vec[4]  = '{3'b111, 32'hFFFF_FFFF,  32'd2,          32'h0000_0001, 33};
    vec[5]  = '{3'b101, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF, 33};
    vec[6]  = '{3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF, 1};
    vec[7]  = '{3'b111, 32'd5,          32'd0,          32'h0000_0005, 1};
    vec[8]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1};
    vec[9]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 1};
    vec[10] = '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 33};
    vec[11] = '{3'b111, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 33};
    vec[12] = '{3'b100, 32'd7,          -32'd2,         32'hFFFF_FFFD, 33};
    vec[13] = '{3'b110, 32'd7,          -32'd2,         32'h0000_0001, 33};
    vec[14] = '{3'b110, -32'd7,         -32'd2,         32'hFFFF_FFFF, 33};
    vec[15] = '{3'b100, 32'd0,          32'd5,          32'h0000_0000, 33};
    vec[16] = '{3'b101, 32'd0,          32'd0,          32'hFFFF_FFFF, 1};
    vec[17] = '{3'b110, -32'd5,         32'd0,          32'hFFFF_FFFB, 1};
    vec[18] = '{3'b100, 32'h8000_0000,  32'd1,          32'h8000_0000, 33};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_r", r, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) rst = 1'b1;
    foreach (vec[i]) run_op(vec[i].f, vec[i].x, vec[i].y, vec[i].e, vec[i].lat, 1'b0);
    // start pulse while busy must not disturb the running divide
    run_op(3'b100, 32'd100, 32'd7, 32'h0000_000E, 33, 1'b1);
    quiet(40);
    // mul code is ignored
    @(negedge clk);
    func3 = 3'b000; a = 32'd5; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("ignored_busy", {31'd0, busy}, 32'd0);
    quiet(40);
    // reset mid-run aborts with no done
    @(negedge clk);
    func3 = 3'b100; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_r", r, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) rst = 1'b1;
    quiet(40);
    run_op(3'b100, 32'd9, 32'd3, 32'h0000_0003, 33, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
